// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - two-master round-robin arbiter for a picorv32-native iomem slave bus
//
// Purpose: shares one iomem slave between master 0 (CPU) and master 1 (DMA/debug).
//   The grant is decided in IDLE, held for exactly one transfer and always released
//   back through IDLE, so each transfer pays one cycle of arbitration.
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   m0_* / m1_*                         master request (valid/addr/wdata/wstrb in, ready/rdata out)
//   s_*                                 slave request (valid/addr/wdata/wstrb out, ready/rdata in)
//   grant                               one-hot owner, 2'b00 in IDLE
//   timeout_irq                         one-cycle pulse on a forced (timed-out) completion
// Configuration: define IOMEM_ARB_TIMEOUT_EN to build the bus-timeout watchdog.

module iomem_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;    // index of the master served most recently
    logic        sel;               // 1 when master 1 owns the bus
    logic        mv;                // owner's valid
    logic        rdy;
    logic [31:0] rdata;

`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT_RDATA, 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant       = 2'b00;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        timeout_irq = 1'b0;
        rdy         = 1'b0;
        rdata       = '0;
        sel         = (state_q == BUSY1);
        mv          = sel ? m1_valid : m0_valid;
`ifdef IOMEM_ARB_TIMEOUT_EN
        // Zero on the first BUSY cycle; counts BUSY cycles spent without s_ready.
        cnt_d       = (state_q == IDLE) ? '0 : (s_ready ? cnt_q : cnt_q + 1'b1);
`endif

        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = last_q ? BUSY0 : BUSY1;
                end else if (m0_valid) begin
                    state_d = BUSY0;
                end else if (m1_valid) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                grant   = sel ? 2'b10 : 2'b01;
                s_valid = mv;
                s_addr  = sel ? m1_addr  : m0_addr;
                s_wdata = sel ? m1_wdata : m0_wdata;
                s_wstrb = sel ? m1_wstrb : m0_wstrb;
                rdy     = s_ready;
                rdata   = s_rdata;
                if (!mv) begin
                    // Owner abandoned the request: release without counting it as served.
                    state_d = IDLE;
                end else if (s_ready) begin
                    state_d = IDLE;
                    last_d  = sel;
                end
`ifdef IOMEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Forced completion: the slave request is withdrawn in the same cycle.
                    rdy         = 1'b1;
                    rdata       = TIMEOUT_RDATA;
                    s_valid     = 1'b0;
                    timeout_irq = 1'b1;
                    state_d     = IDLE;
                    last_d      = sel;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        m0_ready = rdy && (state_q == BUSY0);
        m1_ready = rdy && (state_q == BUSY1);
        m0_rdata = (state_q == BUSY0) ? rdata : 32'h0;
        m1_rdata = (state_q == BUSY1) ? rdata : 32'h0;
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - scoreboard testbench for iomem_arbiter

module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        timeout_irq;

    iomem_arbiter #(.TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          to;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  glog[$];
    logic [1:0]  gprev = 2'b00;
    int          n_cmp = 0, n_bad = 0;
    int          irq_cnt = 0;
    int          slv_delay = 0, slv_cnt = 0;
    bit          slv_never = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] slv_f(input logic [31:0] a);
        return a ^ 32'h1134_5678;
    endfunction

    task automatic push(input int id, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit to);
        exp_t e;
        e.id = id; e.addr = a; e.wdata = wd; e.wstrb = ws; e.to = to;
        e.rdata = to ? 32'hFFFF_FFFF : slv_f(a);
        exp_q.push_back(e);
    endtask

    task automatic drive(input int id, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (id == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end
    endtask

    // Raises a request at the next edge and holds it until ready (bounded).
    task automatic mxfer(input int id, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        int n = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        drive(id, 1'b1, a, wd, ws);
        while (!got && n < 200) begin
            @(negedge clk);
            got = (id == 0) ? m0_ready : m1_ready;
            n++;
        end
        chk("mwait_ready", 64'(got), 1);
    endtask

    task automatic mdrop(input int id);
        @(posedge clk); #1;
        drive(id, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Slave model: completes slv_delay cycles after s_valid rises.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (s_valid && !slv_never && slv_cnt >= slv_delay) begin
                s_ready = 1'b1;
                s_rdata = slv_f(s_addr);
            end else begin
                s_ready = 1'b0;
                s_rdata = '0;
                slv_cnt = s_valid ? slv_cnt + 1 : 0;
            end
        end
    end

    // Monitor: scoreboard on every ready, bus-mux and idle checks every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (grant !== gprev) begin
                    glog.push_back(grant);
                    gprev = grant;
                end
                if (timeout_irq) irq_cnt++;
                if (m0_ready || m1_ready) begin
                    int   id;
                    exp_t e;
                    id = m1_ready ? 1 : 0;
                    chk("one_ready", 64'(m0_ready & m1_ready), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("order_id", 64'(id), 64'(e.id));
                        chk("rdata", id ? m1_rdata : m0_rdata, e.rdata);
                        chk("other_rdata", id ? m0_rdata : m1_rdata, 0);
                        chk("irq", 64'(timeout_irq), 64'(e.to));
                        if (e.to) begin
                            chk("to_svalid", 64'(s_valid), 0);
                        end else begin
                            chk("s_addr", s_addr, e.addr);
                            chk("s_wdata", s_wdata, e.wdata);
                            chk("s_wstrb", 64'(s_wstrb), 64'(e.wstrb));
                        end
                    end
                end else if (timeout_irq) begin
                    chk("stray_irq", 1, 0);
                end
                case (grant)
                    2'b00: chk("idle_zero", 64'(|{s_valid, s_addr, s_wdata, s_wstrb, m0_ready,
                                m1_ready, m0_rdata, m1_rdata, timeout_irq}), 0);
                    2'b01: begin
                        chk("lock0_addr", s_addr, m0_addr);
                        chk("lock0_wdata", s_wdata, m0_wdata);
                        chk("lock0_wstrb", 64'(s_wstrb), 64'(m0_wstrb));
                        chk("lock0_m1rdy", 64'(m1_ready), 0);
                    end
                    2'b10: begin
                        chk("lock1_addr", s_addr, m1_addr);
                        chk("lock1_wdata", s_wdata, m1_wdata);
                        chk("lock1_wstrb", 64'(s_wstrb), 64'(m1_wstrb));
                        chk("lock1_m0rdy", 64'(m0_ready), 0);
                    end
                    default: chk("grant_onehot", 64'(grant), 1);
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_n;
        int busy_n;

        // Reset state
        @(posedge clk); #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_svalid", 64'(s_valid), 0);
        do_reset();

        // Single m0 read: grant at cycle 1, ready at cycle 2
        slv_delay = 1;
        push(0, 32'h0300_0000, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0300_0000, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_c0_grant", 64'(grant), 0);
        @(negedge clk);
        chk("t1_c1_grant", 64'(grant), 64'(2'b01));
        chk("t1_c1_ready", 64'(m0_ready), 0);
        @(negedge clk);
        chk("t1_c2_ready", 64'(m0_ready), 1);
        chk("t1_c2_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_c2_m1rdy", 64'(m1_ready), 0);
        mdrop(0);

        // Simultaneous requests from reset: m0 first, grants 01,00,10,00
        do_reset();
        slv_delay = 0;
        glog.delete();
        push(0, 32'h0300_0004, 32'h1111_0000, 4'hF, 1'b0);
        push(1, 32'h0400_0004, 32'h2222_0000, 4'h3, 1'b0);
        fork
            begin mxfer(0, 32'h0300_0004, 32'h1111_0000, 4'hF); mdrop(0); end
            begin mxfer(1, 32'h0400_0004, 32'h2222_0000, 4'h3); mdrop(1); end
        join
        repeat (3) @(negedge clk);
        chk("t2_glog_len", 64'(glog.size()), 4);
        if (glog.size() == 4) begin
            chk("t2_g0", 64'(glog[0]), 64'(2'b01));
            chk("t2_g1", 64'(glog[1]), 64'(2'b00));
            chk("t2_g2", 64'(glog[2]), 64'(2'b10));
            chk("t2_g3", 64'(glog[3]), 64'(2'b00));
        end

        // Continuous contention: 8 transfers alternating starting with m0
        slv_delay = 2;
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h0300_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), i[0] ? 4'hF : 4'h0, 1'b0);
            push(1, 32'h0400_0200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'(1 << i), 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    mxfer(0, 32'h0300_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), i[0] ? 4'hF : 4'h0);
                mdrop(0);
            end
            begin
                for (int j = 0; j < 4; j++)
                    mxfer(1, 32'h0400_0200 + 32'(4 * j), 32'hB000_0000 + 32'(j), 4'(1 << j));
                mdrop(1);
            end
        join
        repeat (2) @(negedge clk);

        // m1 write locked while m0 arrives mid-transfer
        slv_delay = 3;
        push(1, 32'h0400_0100, 32'hCAFE_F00D, 4'b0011, 1'b0);
        push(0, 32'h0300_0040, 32'h5555_AAAA, 4'h0, 1'b0);
        fork
            begin mxfer(1, 32'h0400_0100, 32'hCAFE_F00D, 4'b0011); mdrop(1); end
            begin
                repeat (2) @(posedge clk);
                mxfer(0, 32'h0300_0040, 32'h5555_AAAA, 4'h0);
                mdrop(0);
            end
        join
        repeat (2) @(negedge clk);

        // Reset during BUSY0, then tie must go to m0 again
        slv_never = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0300_0060, 32'h0, 4'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant != 2'b01 && n < 20);
        chk("t5_busy0", 64'(grant), 64'(2'b01));
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_svalid", 64'(s_valid), 0);
        chk("t5_rst_grant", 64'(grant), 0);
        drive(0, 1'b0, '0, '0, '0);
        @(posedge clk); #1 resetn = 1'b1;
        slv_never = 1'b0;
        slv_delay = 0;
        push(0, 32'h0300_0070, 32'h7777_0000, 4'hC, 1'b0);
        push(1, 32'h0400_0070, 32'h8888_0000, 4'h1, 1'b0);
        fork
            begin mxfer(0, 32'h0300_0070, 32'h7777_0000, 4'hC); mdrop(0); end
            begin mxfer(1, 32'h0400_0070, 32'h8888_0000, 4'h1); mdrop(1); end
        join
        repeat (2) @(negedge clk);

`ifdef IOMEM_ARB_TIMEOUT_EN
        // Slave never answers: forced completion on the 16th BUSY cycle
        slv_never = 1'b1;
        irq_cnt = 0;
        push(0, 32'h0300_0080, 32'h0, 4'h0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0300_0080, 32'h0, 4'h0);
        busy_n = 0;
        n = 0;
        rdy_n = 0;
        while (rdy_n == 0 && n < 100) begin
            @(negedge clk);
            if (grant == 2'b01) busy_n++;
            if (m0_ready) rdy_n = 1;
            n++;
        end
        chk("t6_to_ready", 64'(rdy_n), 1);
        chk("t6_to_cycles", 64'(busy_n), 16);
        mdrop(0);
        repeat (3) @(negedge clk);
        chk("t6_irq_pulses", 64'(irq_cnt), 1);
        slv_never = 1'b0;
`else
        // Without the watchdog a silent slave stalls the master indefinitely
        slv_never = 1'b1;
        busy_n = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0300_0080, 32'h0, 4'h0);
        rdy_n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (m0_ready) rdy_n++;
            if (grant == 2'b01) busy_n++;
        end
        chk("t6_no_ready", 64'(rdy_n), 0);
        chk("t6_held_grant", 64'(busy_n), 999);
        do_reset();
        slv_never = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
